// File: rtl/mmio_sim_monitor.sv
// Store-mapped debug monitor: console FIFOs, sticky tohost status and a cycle watchdog.
// Console push visible next cycle; stores to a full console channel stall via bus_ready=0.

module mmio_mon_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full     = (cnt_q == (PW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module mmio_sim_monitor #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 'h0000_FF00,
    parameter int                NUM_CH         = 2,
    parameter int                FIFO_DEPTH     = 8,
    parameter int                TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bus_we,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [DATA_W-1:0]        bus_wdata,
    output logic                     bus_ready,
    output logic [NUM_CH-1:0]        con_valid,
    output logic [NUM_CH*DATA_W-1:0] con_data,
    input  logic [NUM_CH-1:0]        con_ready,
    output logic                     done,
    output logic                     pass,
    output logic [DATA_W-1:0]        fail_code,
    output logic                     timeout,
    output logic [31:0]              cycle_count,
    output logic [15:0]              drop_count
);
    localparam int OFF_W = ADDR_W - 2;

    logic [OFF_W-1:0]  word_off;
    logic [NUM_CH-1:0] ch_hit, ch_full, ch_empty, ch_push, ch_pop;
    logic              tohost_hit, kick_hit;
    logic              tohost_acc, tohost_eff, kick_acc, wd_expire;
    logic              unused_addr_lsb;

    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] fail_code_q, fail_code_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic [31:0]       wd_cnt_q, wd_cnt_d;

    // Decode on word offsets; addresses below the base wrap to a large offset and miss.
    assign word_off        = bus_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
    assign unused_addr_lsb = ^bus_addr[1:0];
    assign tohost_hit      = bus_we && (word_off == OFF_W'(16));
    assign kick_hit        = bus_we && (word_off == OFF_W'(17));

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign ch_hit[g] = bus_we && (word_off == OFF_W'(g));

            mmio_mon_fifo #(
                .W     (DATA_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .push     (ch_push[g]),
                .push_dat (bus_wdata),
                .pop      (ch_pop[g]),
                .full     (ch_full[g]),
                .empty    (ch_empty[g]),
                .head_dat (con_data[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Fullness is judged before this cycle's pop, so a drain never frees space for a same-cycle push.
    assign bus_ready = ~|(ch_hit & ch_full);
    assign ch_push   = ch_hit & ~ch_full;
    assign con_valid = ~ch_empty;
    assign ch_pop    = con_valid & con_ready;

    assign tohost_acc = tohost_hit && !done_q;
    assign tohost_eff = tohost_acc && (bus_wdata != '0);
    assign kick_acc   = kick_hit && !done_q;
    assign wd_expire  = (TIMEOUT_CYCLES != 0) && !done_q && !kick_acc && !tohost_eff &&
                        (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        fail_code_d   = fail_code_q;
        cycle_count_d = cycle_count_q;
        drop_count_d  = drop_count_q;
        wd_cnt_d      = wd_cnt_q;

        if (!done_q) begin
            if (cycle_count_q != '1) begin
                cycle_count_d = cycle_count_q + 32'd1;
            end
            wd_cnt_d = kick_acc ? 32'd0 : wd_cnt_q + 32'd1;
        end

        if (tohost_eff) begin
            done_d = 1'b1;
            if (bus_wdata == DATA_W'(1)) begin
                pass_d      = 1'b1;
                fail_code_d = '0;
            end else begin
                pass_d      = 1'b0;
                fail_code_d = bus_wdata >> 1;
            end
        end else if (wd_expire) begin
            done_d      = 1'b1;
            pass_d      = 1'b0;
            timeout_d   = 1'b1;
            fail_code_d = '1;
        end

        if (done_q && (tohost_hit || kick_hit) && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
            drop_count_q  <= '0;
            wd_cnt_q      <= '0;
        end else begin
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            fail_code_q   <= fail_code_d;
            cycle_count_q <= cycle_count_d;
            drop_count_q  <= drop_count_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;
    assign drop_count  = drop_count_q;
endmodule

// File: tb/tb_mmio_sim_monitor.sv
// Directed bench for mmio_sim_monitor: vector table plus hand sequences for fill, reset and watchdog.
module tb_mmio_sim_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  con_ready;

    logic        bus_ready, done, pass, timeout;
    logic [1:0]  con_valid;
    logic [63:0] con_data;
    logic [31:0] fail_code, cycle_count;
    logic [15:0] drop_count;

    logic        w_bus_ready, w_done, w_pass, w_timeout;
    logic [1:0]  w_con_valid;
    logic [63:0] w_con_data;
    logic [31:0] w_fail_code, w_cycle_count;
    logic [15:0] w_drop_count;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mmio_sim_monitor #(
        .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0000_FF00),
        .NUM_CH(2), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(100000)
    ) dut (
        .clk(clk), .reset(reset), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .con_valid(con_valid),
        .con_data(con_data), .con_ready(con_ready), .done(done), .pass(pass),
        .fail_code(fail_code), .timeout(timeout), .cycle_count(cycle_count),
        .drop_count(drop_count)
    );

    mmio_sim_monitor #(
        .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0000_FF00),
        .NUM_CH(2), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(20)
    ) dut_wd (
        .clk(clk), .reset(reset), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(w_bus_ready), .con_valid(w_con_valid),
        .con_data(w_con_data), .con_ready(con_ready), .done(w_done), .pass(w_pass),
        .fail_code(w_fail_code), .timeout(w_timeout), .cycle_count(w_cycle_count),
        .drop_count(w_drop_count)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  rdy;
        logic        exp_brdy;
        logic [1:0]  exp_vld;
        logic [31:0] exp_head0;
        logic        exp_done;
        logic        exp_pass;
        logic [31:0] exp_fc;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] rdy);
        @(negedge clk);
        reset     = 1'b0;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = data;
        con_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 32'h0, 32'h0, 2'b00);
            tick();
        end
    endtask

    task automatic rst(input int n);
        @(negedge clk);
        reset     = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        con_ready = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'hFF00, 32'h41, 2'b00, 1'b1, 2'b01, 32'h41, 1'b0, 1'b0, 32'h0, 16'h0};
        tbl[1]  = '{1'b1, 32'hFF00, 32'h42, 2'b00, 1'b1, 2'b01, 32'h41, 1'b0, 1'b0, 32'h0, 16'h0};
        tbl[2]  = '{1'b1, 32'hFF00, 32'h43, 2'b00, 1'b1, 2'b01, 32'h41, 1'b0, 1'b0, 32'h0, 16'h0};
        tbl[3]  = '{1'b0, 32'h0,    32'h0,  2'b01, 1'b1, 2'b01, 32'h42, 1'b0, 1'b0, 32'h0, 16'h0};
        tbl[4]  = '{1'b0, 32'h0,    32'h0,  2'b01, 1'b1, 2'b01, 32'h43, 1'b0, 1'b0, 32'h0, 16'h0};
        tbl[5]  = '{1'b0, 32'h0,    32'h0,  2'b01, 1'b1, 2'b00, 32'h0,  1'b0, 1'b0, 32'h0, 16'h0};
        tbl[6]  = '{1'b1, 32'hFF40, 32'h1,  2'b00, 1'b1, 2'b00, 32'h0,  1'b1, 1'b1, 32'h0, 16'h0};
        tbl[7]  = '{1'b1, 32'hFF40, 32'h7,  2'b00, 1'b1, 2'b00, 32'h0,  1'b1, 1'b1, 32'h0, 16'h1};
        tbl[8]  = '{1'b1, 32'hFF44, 32'h0,  2'b00, 1'b1, 2'b00, 32'h0,  1'b1, 1'b1, 32'h0, 16'h2};
        tbl[9]  = '{1'b1, 32'hFF08, 32'h5,  2'b00, 1'b1, 2'b00, 32'h0,  1'b1, 1'b1, 32'h0, 16'h2};
        tbl[10] = '{1'b1, 32'hFF00, 32'h99, 2'b00, 1'b1, 2'b01, 32'h99, 1'b1, 1'b1, 32'h0, 16'h2};
        tbl[11] = '{1'b1, 32'hFF03, 32'hAA, 2'b00, 1'b1, 2'b01, 32'h99, 1'b1, 1'b1, 32'h0, 16'h2};
        tbl[12] = '{1'b0, 32'h0,    32'h0,  2'b01, 1'b1, 2'b01, 32'hAA, 1'b1, 1'b1, 32'h0, 16'h2};
        tbl[13] = '{1'b0, 32'h0,    32'h0,  2'b01, 1'b1, 2'b00, 32'h0,  1'b1, 1'b1, 32'h0, 16'h2};
        tbl[14] = '{1'b1, 32'hFEFC, 32'h1,  2'b00, 1'b1, 2'b00, 32'h0,  1'b1, 1'b1, 32'h0, 16'h2};

        // Reset state
        rst(2);
        chk("rst bus_ready", 32'(bus_ready), 32'h1);
        chk("rst con_valid", 32'(con_valid), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst pass", 32'(pass), 32'h0);
        chk("rst timeout", 32'(timeout), 32'h0);
        chk("rst fail_code", fail_code, 32'h0);
        chk("rst cycle_count", cycle_count, 32'h0);
        chk("rst drop_count", 32'(drop_count), 32'h0);

        idle(5);
        chk("cycle_count running", cycle_count, 32'd5);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdy);
            #1;
            chk($sformatf("v%0d bus_ready", i), 32'(bus_ready), 32'(tbl[i].exp_brdy));
            tick();
            chk($sformatf("v%0d con_valid", i), 32'(con_valid), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld[0])
                chk($sformatf("v%0d head0", i), con_data[31:0], tbl[i].exp_head0);
            chk($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].exp_done));
            chk($sformatf("v%0d pass", i), 32'(pass), 32'(tbl[i].exp_pass));
            chk($sformatf("v%0d fail_code", i), fail_code, tbl[i].exp_fc);
            chk($sformatf("v%0d drop_count", i), 32'(drop_count), 32'(tbl[i].exp_drop));
        end
        chk("cycle_count frozen", cycle_count, 32'd12);

        // Fill channel 1 past depth with the consumer stalled
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'hFF04, 32'h100 + 32'(i), 2'b00);
            #1;
            chk($sformatf("ch1 fill%0d bus_ready", i), 32'(bus_ready), 32'h1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hFF04, 32'h108, 2'b00);
            #1;
            chk($sformatf("ch1 full stall%0d", i), 32'(bus_ready), 32'h0);
            tick();
        end
        drive(1'b1, 32'hFF04, 32'h108, 2'b10);
        #1;
        chk("ch1 no bypass", 32'(bus_ready), 32'h0);
        chk("ch1 head first", con_data[63:32], 32'h100);
        tick();
        drive(1'b1, 32'hFF04, 32'h108, 2'b00);
        #1;
        chk("ch1 accept after pop", 32'(bus_ready), 32'h1);
        tick();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 32'h0, 32'h0, 2'b10);
            #1;
            chk($sformatf("ch1 drain%0d valid", i), 32'(con_valid[1]), 32'h1);
            chk($sformatf("ch1 drain%0d data", i), con_data[63:32], 32'h100 + 32'(i));
            tick();
        end
        chk("ch1 drained, ch0 idle", 32'(con_valid), 32'h0);
        chk("cycle_count still frozen", cycle_count, 32'd12);

        // Reset mid-operation with pending console data and done set
        drive(1'b1, 32'hFF00, 32'h77, 2'b00);
        tick();
        chk("pre-reset con_valid", 32'(con_valid), 32'h1);
        rst(1);
        chk("midrst con_valid", 32'(con_valid), 32'h0);
        chk("midrst done", 32'(done), 32'h0);
        chk("midrst pass", 32'(pass), 32'h0);
        chk("midrst fail_code", fail_code, 32'h0);
        chk("midrst cycle_count", cycle_count, 32'h0);
        chk("midrst drop_count", 32'(drop_count), 32'h0);
        drive(1'b1, 32'hFF00, 32'h55, 2'b00);
        tick();
        chk("post-rst push valid", 32'(con_valid), 32'h1);
        chk("post-rst push data", con_data[31:0], 32'h55);
        drive(1'b1, 32'hFF40, 32'h15, 2'b00);
        tick();
        chk("fail done", 32'(done), 32'h1);
        chk("fail pass", 32'(pass), 32'h0);
        chk("fail code", fail_code, 32'h0A);
        chk("fail timeout", 32'(timeout), 32'h0);

        // Watchdog expiry exactly 20 cycles after a kick
        rst(1);
        idle(15);
        drive(1'b1, 32'hFF44, 32'h0, 2'b00);
        tick();
        idle(19);
        chk("wd before expiry timeout", 32'(w_timeout), 32'h0);
        chk("wd before expiry done", 32'(w_done), 32'h0);
        idle(1);
        chk("wd timeout", 32'(w_timeout), 32'h1);
        chk("wd done", 32'(w_done), 32'h1);
        chk("wd pass", 32'(w_pass), 32'h0);
        chk("wd fail_code", w_fail_code, 32'hFFFF_FFFF);
        chk("wd cycle_count", w_cycle_count, 32'd36);
        idle(2);
        chk("wd cycle_count frozen", w_cycle_count, 32'd36);

        // TOHOST landing in the expiry cycle wins
        rst(1);
        idle(15);
        drive(1'b1, 32'hFF44, 32'h0, 2'b00);
        tick();
        idle(19);
        drive(1'b1, 32'hFF40, 32'h1, 2'b00);
        tick();
        chk("race done", 32'(w_done), 32'h1);
        chk("race pass", 32'(w_pass), 32'h1);
        chk("race timeout", 32'(w_timeout), 32'h0);
        chk("race fail_code", w_fail_code, 32'h0);
        idle(2);
        chk("race timeout stays clear", 32'(w_timeout), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end
endmodule
